// File: rtl/apb_pkg.sv
// Shared definitions for the APB register bank: FSM encoding, bus byte geometry
// and the decode error causes.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_BYTE_W = 8;
    localparam int APB_STRB_W = 32 / APB_BYTE_W;

    typedef enum logic [1:0] {
        ERR_RANGE  = 2'd0,
        ERR_ALIGN  = 2'd1,
        ERR_RO     = 2'd2,
        ERR_RDSTRB = 2'd3
    } apb_err_e;

    localparam int APB_ERR_N = 4;

    // One bit per cause so a waveform shows why a transfer was rejected.
    function automatic logic [APB_ERR_N-1:0] err_set(
        input logic range_bad,
        input logic align_bad,
        input logic ro_bad,
        input logic rdstrb_bad
    );
        logic [APB_ERR_N-1:0] m;
        m             = '0;
        m[ERR_RANGE]  = range_bad;
        m[ERR_ALIGN]  = align_bad;
        m[ERR_RO]     = ro_bad;
        m[ERR_RDSTRB] = rdstrb_bad;
        return m;
    endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB4 completer-side bus bundle; the master modport drives requests, the
// slave modport returns PREADY/PRDATA/PSLVERR.
interface apb_slave_regbank_if
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                                 apb_psel_in;
    logic                                 apb_penable_in;
    logic                                 apb_write_in;
    logic [APB_ADDR_WIDTH-1:0]            apb_addr_in;
    logic [APB_DATA_WIDTH-1:0]            apb_wdata_in;
    logic [APB_DATA_WIDTH/APB_BYTE_W-1:0] apb_strb_in;
    logic [2:0]                           apb_prot_in;
    logic                                 apb_ready_out;
    logic [APB_DATA_WIDTH-1:0]            apb_rdata_out;
    logic                                 apb_slverr_out;

    modport master (
        output apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in,
               apb_wdata_in, apb_strb_in, apb_prot_in,
        input  apb_ready_out, apb_rdata_out, apb_slverr_out
    );

    modport slave (
        input  apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in,
               apb_wdata_in, apb_strb_in, apb_prot_in,
        output apb_ready_out, apb_rdata_out, apb_slverr_out
    );
endinterface

// File: rtl/apb_wait_counter.sv
// 4-bit loadable down-counter pacing APB wait states; done flags the last
// wait cycle.
module apb_wait_counter (
    input  logic       apb_clk_in,
    input  logic       apb_rstn_in,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);
    logic [3:0] cnt_q;

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done = (cnt_q == 4'd1);
endmodule

// File: rtl/apb_slave_regbank.sv
// APB4 completer exposing a bank of control registers; register 0 reads the
// live status input. Optional wait states compiled in with APB_SLAVE_WAIT_EN.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int NUM_REGS       = 8,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                               apb_clk_in,
    input  logic                               apb_rstn_in,
    apb_slave_regbank_if.slave                 apb,
    input  logic [APB_DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_data_out,
    output logic [NUM_REGS-1:0]                reg_wr_pulse_out
);
    localparam int W         = APB_DATA_WIDTH;
    localparam int A         = APB_ADDR_WIDTH;
    localparam int STRB_W    = W / APB_BYTE_W;
    localparam int IDX_W     = A - 2;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
`ifdef APB_SLAVE_WAIT_EN
    localparam int WAIT_N    = WAIT_CYCLES;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`else
    localparam int WAIT_N    = 0;
`endif

    // ---- address/strobe decode of the bus as currently presented ----
    logic [IDX_W-1:0]     dec_idx_full;
    logic [REG_IDX_W-1:0] dec_idx;
    logic [APB_ERR_N-1:0] dec_causes;
    logic                 dec_err;
    logic                 setup_seen;

    assign dec_idx_full = apb.apb_addr_in[A-1:2];
    assign dec_idx      = dec_idx_full[REG_IDX_W-1:0];
    assign dec_causes   = err_set(dec_idx_full >= IDX_W'(NUM_REGS),
                                  apb.apb_addr_in[1:0] != 2'b00,
                                  apb.apb_write_in && (dec_idx_full == '0),
                                  !apb.apb_write_in && (|apb.apb_strb_in));
    assign dec_err      = |dec_causes;
    assign setup_seen   = apb.apb_psel_in && !apb.apb_penable_in;

    logic unused_prot;
    assign unused_prot = ^apb.apb_prot_in;

    // ---- transfer latched at the setup edge ----
    logic                 lat_err_q;
    logic                 lat_write_q;
    logic [REG_IDX_W-1:0] lat_idx_q;
    logic [W-1:0]         lat_wdata_q;
    logic [STRB_W-1:0]    lat_strb_q;
    logic [W-1:0]         lat_status_q;

    apb_state_e state_q, state_d;
    logic       load_xfer, go_access, drop_out, commit;
    logic       cnt_done;

`ifdef APB_SLAVE_WAIT_EN
    apb_wait_counter u_wait_counter (
        .apb_clk_in  (apb_clk_in),
        .apb_rstn_in (apb_rstn_in),
        .load        (load_xfer),
        .load_val    (WAIT_LD),
        .dec         (state_q == ST_WAIT),
        .done        (cnt_done)
    );
`else
    assign cnt_done = 1'b0;
`endif

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_xfer = 1'b0;
        go_access = 1'b0;
        drop_out  = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (setup_seen) begin
                    load_xfer = 1'b1;
                    if (WAIT_N == 0) begin
                        state_d   = ST_ACCESS;
                        go_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
`ifdef APB_SLAVE_WAIT_EN
            ST_WAIT: begin
                if (!apb.apb_psel_in) begin
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    state_d   = ST_ACCESS;
                    go_access = 1'b1;
                end
            end
`endif
            ST_ACCESS: begin
                drop_out = 1'b1;
                if (!apb.apb_psel_in) begin
                    state_d = ST_IDLE;
                end else if (apb.apb_penable_in) begin
                    commit  = lat_write_q && !lat_err_q;
                    state_d = ST_IDLE;
                end else begin
                    // Master skipped straight to a new setup phase.
                    load_xfer = 1'b1;
                    if (WAIT_N == 0) begin
                        state_d   = ST_ACCESS;
                        go_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            lat_err_q   <= 1'b0;
            lat_write_q <= 1'b0;
        end else if (load_xfer) begin
            lat_err_q   <= dec_err;
            lat_write_q <= apb.apb_write_in;
        end
    end

    always_ff @(posedge apb_clk_in) begin
        if (load_xfer) begin
            lat_idx_q    <= dec_idx;
            lat_wdata_q  <= apb.apb_wdata_in;
            lat_strb_q   <= apb.apb_strb_in;
            lat_status_q <= status_in;
        end
    end

    // ---- response source: live decode on a zero-wait setup, else the latch ----
    logic                 src_err, src_write;
    logic [REG_IDX_W-1:0] src_idx;
    logic [W-1:0]         src_status, src_rdata;
    logic [W-1:0]         regs_q [1:NUM_REGS-1];

    assign src_err    = load_xfer ? dec_err : lat_err_q;
    assign src_write  = load_xfer ? apb.apb_write_in : lat_write_q;
    assign src_idx    = load_xfer ? dec_idx : lat_idx_q;
    assign src_status = load_xfer ? status_in : lat_status_q;

    always_comb begin
        src_rdata = src_status;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (src_idx == REG_IDX_W'(i)) begin
                src_rdata = regs_q[i];
            end
        end
    end

    logic         ready_q, slverr_q;
    logic [W-1:0] rdata_q;

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else if (go_access) begin
            ready_q  <= 1'b1;
            slverr_q <= src_err;
            rdata_q  <= (src_err || src_write) ? '0 : src_rdata;
        end else if (drop_out) begin
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end
    end

    assign apb.apb_ready_out  = ready_q;
    assign apb.apb_slverr_out = slverr_q;
    assign apb.apb_rdata_out  = rdata_q;

    // ---- register bank commit at the access-ending edge ----
    logic [NUM_REGS-1:0] wr_pulse_q;

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit && (lat_idx_q == REG_IDX_W'(i))) begin
                    wr_pulse_q[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (lat_strb_q[b]) begin
                            regs_q[i][b*APB_BYTE_W +: APB_BYTE_W] <=
                                lat_wdata_q[b*APB_BYTE_W +: APB_BYTE_W];
                        end
                    end
                end
            end
        end
    end

    assign reg_wr_pulse_out = wr_pulse_q;
    assign reg_data_out[0 +: W] = status_in;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_data_out[g*W +: W] = regs_q[g];
    end

    a_err_needs_ready : assert property (
        @(posedge apb_clk_in) disable iff (!apb_rstn_in) slverr_q |-> ready_q);
    a_pulse_onehot : assert property (
        @(posedge apb_clk_in) disable iff (!apb_rstn_in) $onehot0(wr_pulse_q));
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: driver pushes expected responses from a register
// model; an independent monitor pops and compares whenever PREADY completes a transfer.
module tb_apb_slave_regbank;
    localparam int NREGS = 8;
    localparam int WAITS = 3;
`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = WAITS;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    apb_slave_regbank_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    logic [31:0]         status;
    logic [NREGS*32-1:0] reg_data;
    logic [NREGS-1:0]    wr_pulse;

    apb_slave_regbank #(
        .APB_DATA_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .NUM_REGS       (NREGS),
        .WAIT_CYCLES    (WAITS)
    ) dut (
        .apb_clk_in       (clk),
        .apb_rstn_in      (rstn),
        .apb              (bus),
        .status_in        (status),
        .reg_data_out     (reg_data),
        .reg_wr_pulse_out (wr_pulse)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          slverr;
        int          waits;
        logic [7:0]  pulse;
        bit          chk_reg;
        int          idx;
        logic [31:0] regval;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [NREGS];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Reference model: APB register bank behaviour expressed directly in words/bytes.
    task automatic predict(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] stat);
        exp_t        e;
        logic [31:0] idx;
        bit          err;
        idx = addr >> 2;
        err = (idx >= NREGS) || (addr % 4 != 0) || (wr && idx == 0) || (!wr && strb != 0);
        e.slverr    = err;
        e.waits     = EXP_WAITS;
        e.pulse     = '0;
        e.chk_rdata = !wr;
        e.rdata     = '0;
        e.chk_reg   = 0;
        e.idx       = 0;
        e.regval    = '0;
        if (!wr && !err) e.rdata = (idx == 0) ? stat : model[idx];
        if (wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
            e.pulse = 8'(1 << idx);
        end
        if (!err && idx != 0) begin
            e.chk_reg = 1;
            e.idx     = int'(idx);
            e.regval  = model[idx];
        end
        exp_q.push_back(e);
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
        int n;
        status = $urandom;
        predict(wr, addr, wdata, strb, status);
        bus.apb_psel_in    = 1'b1;
        bus.apb_penable_in = 1'b0;
        bus.apb_write_in   = wr;
        bus.apb_addr_in    = addr;
        bus.apb_wdata_in   = wdata;
        bus.apb_strb_in    = strb;
        bus.apb_prot_in    = 3'($urandom);
        @(posedge clk); #1;
        status = $urandom;
        bus.apb_penable_in = 1'b1;
        n = 0;
        while (!bus.apb_ready_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.apb_ready_out) begin
            n_checks++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        bus.apb_psel_in    = 1'b0;
        bus.apb_penable_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: completes transfers against the queue and polices the write pulse.
    initial begin : monitor
        int   waits;
        bit   pend;
        exp_t pe, e;
        waits = 0;
        pend  = 0;
        forever begin
            @(negedge clk);
            chk("wr_pulse", 64'(wr_pulse), pend ? 64'(pe.pulse) : 64'd0);
            if (pend && pe.chk_reg)
                chk($sformatf("reg%0d_value", pe.idx), 64'(reg_data[pe.idx*32 +: 32]), 64'(pe.regval));
            pend = 0;
            if (rstn && bus.apb_psel_in && bus.apb_penable_in) begin
                if (!bus.apb_ready_out) begin
                    waits++;
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ready: ready 1 with no transfer pending, required 0");
                    waits = 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("slverr", 64'(bus.apb_slverr_out), 64'(e.slverr));
                    if (e.chk_rdata) chk("rdata", 64'(bus.apb_rdata_out), 64'(e.rdata));
                    chk("wait_states", 64'(waits), 64'(e.waits));
                    pe    = e;
                    pend  = 1;
                    waits = 0;
                end
            end else begin
                waits = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r;
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          w;

        bus.apb_psel_in    = 1'b0;
        bus.apb_penable_in = 1'b0;
        bus.apb_write_in   = 1'b0;
        bus.apb_addr_in    = '0;
        bus.apb_wdata_in   = '0;
        bus.apb_strb_in    = '0;
        bus.apb_prot_in    = '0;
        status             = 32'hA5A5_0001;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("reset_ready",  64'(bus.apb_ready_out),  64'd0);
        chk("reset_rdata",  64'(bus.apb_rdata_out),  64'd0);
        chk("reset_slverr", 64'(bus.apb_slverr_out), 64'd0);
        chk("reset_pulse",  64'(wr_pulse),           64'd0);
        chk("reset_status_slice", 64'(reg_data[31:0]), 64'hA5A5_0001);
        for (int i = 1; i < NREGS; i++)
            chk($sformatf("reset_reg%0d", i), 64'(reg_data[i*32 +: 32]), 64'd0);
        idle(1);

        // Directed cases, issued back to back.
        xfer(1, 32'h04, 32'hDEAD_BEEF, 4'hF);
        xfer(0, 32'h04, 32'h0, 4'h0);
        xfer(1, 32'h08, 32'h1122_3344, 4'h5);
        xfer(0, 32'h08, 32'h0, 4'h0);
        xfer(1, 32'h00, 32'hFFFF_FFFF, 4'hF);
        xfer(0, 32'h00, 32'h0, 4'h0);
        xfer(0, 32'h20, 32'h0, 4'h0);
        xfer(0, 32'h06, 32'h0, 4'h0);
        xfer(0, 32'h0C, 32'h0, 4'h1);
        xfer(1, 32'h0D, 32'h1234_5678, 4'hF);
        xfer(1, 32'h1C, 32'hCAFE_F00D, 4'hF);
        idle(2);

        // Abandon a write by dropping psel before it completes.
        bus.apb_psel_in    = 1'b1;
        bus.apb_penable_in = 1'b0;
        bus.apb_write_in   = 1'b1;
        bus.apb_addr_in    = 32'h10;
        bus.apb_wdata_in   = 32'h5555_AAAA;
        bus.apb_strb_in    = 4'hF;
        @(posedge clk); #1;
`ifdef APB_SLAVE_WAIT_EN
        bus.apb_penable_in = 1'b1;
        @(posedge clk); #1;
`endif
        bus.apb_psel_in    = 1'b0;
        bus.apb_penable_in = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 64'(bus.apb_ready_out), 64'd0);
        chk("abort_reg4",  64'(reg_data[4*32 +: 32]), 64'(model[4]));
        xfer(0, 32'h10, 32'h0, 4'h0);
        idle(1);

        // Reset asserted during the access phase of a write.
        bus.apb_psel_in    = 1'b1;
        bus.apb_penable_in = 1'b0;
        bus.apb_write_in   = 1'b1;
        bus.apb_addr_in    = 32'h0C;
        bus.apb_wdata_in   = 32'h9ABC_DEF0;
        bus.apb_strb_in    = 4'hF;
        @(posedge clk); #1;
        bus.apb_penable_in = 1'b1;
        r = 0;
        while (!bus.apb_ready_out && r < 50) begin
            @(posedge clk); #1;
            r++;
        end
        chk("rst_test_reached_access", 64'(bus.apb_ready_out), 64'd1);
        #1 rstn = 1'b0;
        #1;
        chk("midreset_ready",  64'(bus.apb_ready_out),  64'd0);
        chk("midreset_slverr", 64'(bus.apb_slverr_out), 64'd0);
        chk("midreset_reg3",   64'(reg_data[3*32 +: 32]), 64'd0);
        chk("midreset_reg1",   64'(reg_data[1*32 +: 32]), 64'd0);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        bus.apb_psel_in    = 1'b0;
        bus.apb_penable_in = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        idle(1);
        xfer(0, 32'h0C, 32'h0, 4'h0);

        // Randomized traffic.
        for (int k = 0; k < 250; k++) begin
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, NREGS - 1)) << 2;
            else if (r == 7) a = 32'($urandom_range(0, 63));
            else if (r == 8) a = $urandom;
            else             a = 32'($urandom_range(NREGS, 2 * NREGS - 1)) << 2;
            d = $urandom;
            if (w)                              s = 4'($urandom);
            else if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(1, 15));
            else                                s = 4'h0;
            xfer(w, a, d, s);
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
